alu_result_tx: RTL and testbench
================================

# alu_result_tx

Serial transmitter for the ALU board. It takes a parallel result word, such as the ALU output, and sends it LSB-first as an asynchronous UART frame (8N1 by default) on a single line. It is the output-side counterpart of the switch/button operand loader: operands enter through the board inputs, and results leave through this block to a host UART. A simple start/busy/done handshake lets a controller trigger one frame per result.

## Interface

Parameters:
- BITS_DATA, 8, data bits per frame.
- CLKS_PER_BIT, 2604, clock cycles per serial bit (50 MHz / 19200 baud). Must be ≥ 2.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_tx_start  input  1  request to send; sampled only in IDLE.
- i_data  input  BITS_DATA  word to send; captured in the cycle the start is accepted.
- o_tx  output  1  serial line; idles high.
- o_tx_busy  output  1  high from the cycle after acceptance until the frame ends.
- o_tx_done  output  1  one-cycle pulse at the end of the last stop bit.

## Operation

- Reset values (applied immediately while i_reset is high):
  - o_tx = 1, o_tx_busy = 0, o_tx_done = 0.
  - State = IDLE; bit counter, clock counter and shift register = 0.
- States are IDLE, START, DATA and STOP.
- IDLE:
  - o_tx = 1.
  - If i_tx_start = 1 at a clock edge: latch i_data into the shift register, clear the clock counter, go to START.
- START:
  - o_tx = 0 for CLKS_PER_BIT cycles, then go to DATA with the bit index at 0.
- DATA:
  - o_tx = shift register bit 0.
  - After CLKS_PER_BIT cycles: shift right by one and increment the bit index.
  - After bit BITS_DATA-1 completes, go to STOP.
- STOP:
  - o_tx = 1 for STOP_BITS × CLKS_PER_BIT cycles.
  - On the final cycle, pulse o_tx_done and go to IDLE.
- Clock counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Cleared on every state entry. It never free-runs, so all bit periods are exact.
- o_tx_busy = (state != IDLE). It is registered and decoded from the state.
- o_tx is driven from a register, so the line is glitch-free.
- i_tx_start is ignored while busy: no queuing and no error flag.
- i_data changes after acceptance have no effect on the frame in flight.
- Start held high continuously:
  - A new frame is accepted on the first IDLE cycle after o_tx_done.
  - This gives one idle-high cycle between frames.
- Reset mid-frame:
  - The frame is aborted.
  - o_tx returns high asynchronously, with no done pulse.
  - A new frame may be accepted on the first edge after i_reset deasserts.

## Timing

- Accept edge T (IDLE, i_tx_start = 1): o_tx falls at T+1 and o_tx_busy rises at T+1.
- Start bit: cycles T+1 .. T+CLKS_PER_BIT.
- Data bit k: cycles T+1+(k+1)·CLKS_PER_BIT .. T+(k+2)·CLKS_PER_BIT.
- Frame length: F = (1 + BITS_DATA + STOP_BITS) × CLKS_PER_BIT cycles.
- o_tx_done is high during cycle T+F, the last stop-bit cycle.
- At T+F+1: o_tx_busy = 0 and the state is IDLE.
- Earliest next accept edge: T+F+1. The next start bit begins at T+F+2.

## Test plan

- Reset then idle: hold i_reset for 3 cycles, then release with no start → o_tx = 1, o_tx_busy = 0 and o_tx_done = 0 for 100 cycles.
- Single frame (CLKS_PER_BIT = 4, i_data = 0xA5, one-cycle start):
  - o_tx samples at the bit centers are 0, 1,0,1,0,0,1,0,1, 1.
  - Each level lasts exactly 4 cycles; busy is high for 40 cycles.
  - o_tx_done pulses once, at cycle 40 after acceptance.
- Ignored start: with CLKS_PER_BIT = 4, send 0x3C, and at cycle 10 assert start with i_data = 0xFF → the line still shows 0x3C (0,0,1,1,1,1,0,0 LSB-first) and exactly one done pulse.
- Back-to-back frames: hold i_tx_start high with 0x01 then 0x80 → two complete frames separated by exactly one idle-high cycle, with two done pulses.
- Reset mid-frame: assert i_reset during data bit 3 of 0x00 → o_tx goes high in the same cycle, busy goes low, no done pulse; the next start sends a clean full frame.
- STOP_BITS = 2, CLKS_PER_BIT = 4, data 0xFF → line high for 8 cycles after bit 7; the done pulse arrives at cycle 44 after acceptance.

Source files
------------

// File: rtl/alu_result_tx.sv
// UART-style serial transmitter: sends one parallel result word LSB-first
// as a start/data/stop frame with a start/busy/done handshake.
module alu_result_tx #(
  parameter int unsigned BITS_DATA    = 8,
  parameter int unsigned CLKS_PER_BIT = 2604,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_tx_start,
  input  logic [BITS_DATA-1:0] i_data,
  output logic                 o_tx,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_MAX = (BITS_DATA > STOP_BITS) ? BITS_DATA : STOP_BITS;
  localparam int unsigned BIT_W   = $clog2(BIT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(BITS_DATA - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]           state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [BIT_W-1:0]     bit_idx, bit_idx_n;
  logic [BITS_DATA-1:0] shreg, shreg_n;
  logic                 tx_n, busy_n, done_n;

  // Outputs are decoded from the next state so they line up with it cycle-for-cycle.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      o_tx      <= 1'b1;
      o_tx_busy <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      o_tx      <= tx_n;
      o_tx_busy <= busy_n;
      o_tx_done <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_n      = 1'b1;
    busy_n    = 1'b0;
    done_n    = 1'b0;

    case (state)
      IDLE: begin
        if (i_tx_start) begin
          shreg_n   = i_data;
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = START;
        end
      end
      START: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          shreg_n = shreg >> 1;
          if (bit_idx == DATA_LAST) begin
            bit_idx_n = '0;
            state_n   = STOP;
          end else begin
            bit_idx_n = bit_idx + BIT_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        // Stop bits reuse the bit index so multi-stop periods stay exact.
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (bit_idx == STOP_LAST) begin
            bit_idx_n = '0;
            state_n   = IDLE;
          end else begin
            bit_idx_n = bit_idx + BIT_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase

    busy_n = (state_n != IDLE);
    done_n = (state_n == STOP) && (cnt_n == CNT_LAST) && (bit_idx_n == STOP_LAST);
  end

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx: reset/idle, frame shape, ignored start,
// back-to-back frames, mid-frame reset and a two-stop-bit instance.
module tb_alu_result_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start2;
  logic [7:0] data, data2;
  logic       tx, busy, done;
  logic       tx2, busy2, done2;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  alu_result_tx #(.BITS_DATA(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .clk(clk), .i_reset(rst), .i_tx_start(start), .i_data(data),
    .o_tx(tx), .o_tx_busy(busy), .o_tx_done(done)
  );

  alu_result_tx #(.BITS_DATA(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .i_reset(rst), .i_tx_start(start2), .i_data(data2),
    .o_tx(tx2), .o_tx_busy(busy2), .o_tx_done(done2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called in cycle T+1; frame is {stop, data[7:0], start} with bit 0 sent first.
  task automatic check_frame(input string tag, input logic [9:0] frame, input int inject_n);
    int dones;
    dones = 0;
    for (int n = 1; n <= 40; n++) begin
      chk($sformatf("%s_tx_c%0d", tag, n), 32'(tx), 32'(frame[(n-1)/4]));
      chk($sformatf("%s_busy_c%0d", tag, n), 32'(busy), 32'd1);
      chk($sformatf("%s_done_c%0d", tag, n), 32'(done), (n == 40) ? 32'd1 : 32'd0);
      if (done) dones++;
      if (n == inject_n) begin
        start = 1'b1;
        data  = 8'hFF;
      end else if (n == inject_n + 1) begin
        start = 1'b0;
      end
      tick();
    end
    chk({tag, "_idle_tx"}, 32'(tx), 32'd1);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_done_count"}, 32'(dones), 32'd1);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    data   = 8'h00;
    data2  = 8'h00;

    // Reset held for three cycles, then idle with no start.
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_tx_%0d", i), 32'(tx), 32'd1);
      chk($sformatf("rst_busy_%0d", i), 32'(busy), 32'd0);
      chk($sformatf("rst_done_%0d", i), 32'(done), 32'd0);
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      chk($sformatf("idle_tx_%0d", i), 32'(tx), 32'd1);
      chk($sformatf("idle_busy_%0d", i), 32'(busy), 32'd0);
      chk($sformatf("idle_done_%0d", i), 32'(done), 32'd0);
      chk($sformatf("idle_tx2_%0d", i), 32'(tx2), 32'd1);
      tick();
    end

    // Single frame 0xA5: levels 0,1,0,1,0,0,1,0,1,1.
    data  = 8'hA5;
    start = 1'b1;
    tick();
    start = 1'b0;
    data  = 8'h00;
    check_frame("a5", 10'b1_10100101_0, -5);
    tick();

    // 0x3C with a start/0xFF pulse during cycle 10 that must be ignored.
    data  = 8'h3C;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_frame("3c", 10'b1_00111100_0, 10);
    tick();

    // Start held high: 0x01 then 0x80 with one idle-high cycle between.
    data  = 8'h01;
    start = 1'b1;
    tick();
    data = 8'h80;
    check_frame("b2b0", 10'b1_00000001_0, -5);
    tick();
    start = 1'b0;
    check_frame("b2b1", 10'b1_10000000_0, -5);
    tick();

    // Reset during data bit 3 of 0x00 (frame cycles 17..20).
    data  = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 18; n++) tick();
    chk("mid_tx_before", 32'(tx), 32'd0);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_tx_async", 32'(tx), 32'd1);
    chk("mid_busy_async", 32'(busy), 32'd0);
    chk("mid_done_async", 32'(done), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("mid_hold_tx_%0d", i), 32'(tx), 32'd1);
      chk($sformatf("mid_hold_done_%0d", i), 32'(done), 32'd0);
    end
    rst   = 1'b0;
    data  = 8'hC3;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_frame("post_rst", 10'b1_11000011_0, -5);
    tick();

    // Two stop bits, 0xFF: done at cycle 44, busy low at 45.
    data2  = 8'hFF;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int n = 1; n <= 44; n++) begin
      chk($sformatf("sb2_tx_c%0d", n), 32'(tx2), (n <= 4) ? 32'd0 : 32'd1);
      chk($sformatf("sb2_busy_c%0d", n), 32'(busy2), 32'd1);
      chk($sformatf("sb2_done_c%0d", n), 32'(done2), (n == 44) ? 32'd1 : 32'd0);
      tick();
    end
    chk("sb2_end_busy", 32'(busy2), 32'd0);
    chk("sb2_end_done", 32'(done2), 32'd0);
    chk("sb2_end_tx", 32'(tx2), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
